// File: rtl/input_port_credit.sv
// Router input port: one flit FIFO per virtual channel, per-VC packet FSM with XY
// routing on the head flit, downstream VC relabelling and upstream credit return.
module input_port_credit #(
    parameter int unsigned VC_NUM      = 2,
    parameter int unsigned BUFFER_SIZE = 8,
    parameter int unsigned FLIT_W      = 32,
    parameter int unsigned DX          = 2,
    parameter int unsigned DY          = 2,
    parameter int unsigned X_CURRENT   = 0,
    parameter int unsigned Y_CURRENT   = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [FLIT_W-1:0]                flit_i,
    input  logic                             valid_flit_i,
    input  logic [VC_NUM-1:0]                va_valid_i,
    input  logic [VC_NUM*$clog2(VC_NUM)-1:0] va_new_vc_i,
    input  logic                             sa_valid_i,
    input  logic [$clog2(VC_NUM)-1:0]        sa_sel_vc_i,
    output logic [FLIT_W-1:0]                xb_flit_o,
    output logic                             xb_valid_o,
    output logic [VC_NUM-1:0]                va_request_o,
    output logic [VC_NUM-1:0]                sa_request_o,
    output logic [VC_NUM*3-1:0]              out_port_o,
    output logic                             credit_valid_o,
    output logic [$clog2(VC_NUM)-1:0]        credit_vc_o,
    output logic [VC_NUM-1:0]                is_empty_o,
    output logic [VC_NUM-1:0]                err_o
);

    localparam int unsigned VCW    = $clog2(VC_NUM);
    localparam int unsigned PW     = $clog2(BUFFER_SIZE);
    localparam int unsigned CW     = PW + 1;
    localparam int unsigned VC_LSB = FLIT_W - 2 - VCW;

    localparam logic [DX-1:0] X_CUR = DX'(X_CURRENT);
    localparam logic [DY-1:0] Y_CUR = DY'(Y_CURRENT);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_VA     = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    localparam logic [2:0] PORT_LOCAL = 3'd0;
    localparam logic [2:0] PORT_N     = 3'd1;
    localparam logic [2:0] PORT_S     = 3'd2;
    localparam logic [2:0] PORT_W     = 3'd3;
    localparam logic [2:0] PORT_E     = 3'd4;

    logic [FLIT_W-1:0] mem_q [VC_NUM][BUFFER_SIZE];
    logic [PW-1:0]     rd_ptr_q [VC_NUM];
    logic [PW-1:0]     wr_ptr_q [VC_NUM];
    logic [CW-1:0]     count_q [VC_NUM];

    logic [1:0]        state_q [VC_NUM];
    logic [1:0]        state_d [VC_NUM];
    logic [2:0]        route_q [VC_NUM];
    logic [2:0]        route_d [VC_NUM];
    logic [VCW-1:0]    down_vc_q [VC_NUM];
    logic [VCW-1:0]    down_vc_d [VC_NUM];

    logic [FLIT_W-1:0] head [VC_NUM];
    logic [VC_NUM-1:0] empty;
    logic [VC_NUM-1:0] full;
    logic [VC_NUM-1:0] wr_hit;
    logic [VC_NUM-1:0] sel_hit;
    logic [VC_NUM-1:0] sa_pop;
    logic [VC_NUM-1:0] sa_err;
    logic [VC_NUM-1:0] idle_bad;
    logic [VC_NUM-1:0] drop;
    logic [VC_NUM-1:0] pop;
    logic [VC_NUM-1:0] push;
    logic [VC_NUM-1:0] err_set;
    logic [VC_NUM-1:0] err_q;
    logic              drop_blocked;
    logic [VCW-1:0]    pop_vc;
    logic              credit_valid_q;
    logic [VCW-1:0]    credit_vc_q;

    // XY dimension-order routing: resolve X first, then Y.
    function automatic logic [2:0] xy_route(input logic [FLIT_W-1:0] f);
        logic [DX-1:0] x_dst;
        logic [DY-1:0] y_dst;
        x_dst = f[DX-1:0];
        y_dst = f[DX+DY-1:DX];
        if (x_dst > X_CUR) begin
            xy_route = PORT_E;
        end else if (x_dst != X_CUR) begin
            xy_route = PORT_W;
        end else if (y_dst > Y_CUR) begin
            xy_route = PORT_S;
        end else if (y_dst != Y_CUR) begin
            xy_route = PORT_N;
        end else begin
            xy_route = PORT_LOCAL;
        end
    endfunction

    // FIFO status, grant decode and the combinational crossbar path.
    always_comb begin
        xb_valid_o = 1'b0;
        xb_flit_o  = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            head[v]     = mem_q[v][rd_ptr_q[v]];
            empty[v]    = (count_q[v] == '0);
            full[v]     = (count_q[v] == CW'(BUFFER_SIZE));
            wr_hit[v]   = valid_flit_i && (flit_i[FLIT_W-3 -: VCW] == VCW'(v));
            sel_hit[v]  = sa_valid_i && (sa_sel_vc_i == VCW'(v));
            sa_pop[v]   = sel_hit[v] && (state_q[v] == ST_ACTIVE) && !empty[v];
            sa_err[v]   = sel_hit[v] && !sa_pop[v];
            // BODY (01) and TAIL (10) are the labels whose two bits differ.
            idle_bad[v] = (state_q[v] == ST_IDLE) && !empty[v] &&
                          (head[v][FLIT_W-1] != head[v][FLIT_W-2]);
            if (sa_pop[v]) begin
                xb_valid_o = 1'b1;
                xb_flit_o  = {head[v][FLIT_W-1 -: 2], down_vc_q[v], head[v][VC_LSB-1:0]};
            end
        end
    end

    // One credit per cycle: a switch pop wins, otherwise the lowest VC with a stray
    // BODY/TAIL head is dropped; other stray heads wait for a free cycle.
    always_comb begin
        drop         = '0;
        drop_blocked = |sa_pop;
        for (int v = 0; v < VC_NUM; v++) begin
            if (!drop_blocked && idle_bad[v]) begin
                drop[v]      = 1'b1;
                drop_blocked = 1'b1;
            end
        end
        pop    = sa_pop | drop;
        pop_vc = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            if (pop[v]) begin
                pop_vc = VCW'(v);
            end
        end
        for (int v = 0; v < VC_NUM; v++) begin
            push[v]    = wr_hit[v] && (!full[v] || pop[v]);
            err_set[v] = sa_err[v] || drop[v] || (wr_hit[v] && full[v] && !pop[v]);
        end
    end

    // Per-VC packet FSM.
    always_comb begin
        for (int v = 0; v < VC_NUM; v++) begin
            state_d[v]   = state_q[v];
            route_d[v]   = route_q[v];
            down_vc_d[v] = down_vc_q[v];
            case (state_q[v])
                ST_IDLE: begin
                    if (!empty[v] && (head[v][FLIT_W-1] == head[v][FLIT_W-2])) begin
                        state_d[v] = ST_VA;
                        route_d[v] = xy_route(head[v]);
                    end
                end
                ST_VA: begin
                    if (va_valid_i[v]) begin
                        state_d[v]   = ST_ACTIVE;
                        down_vc_d[v] = va_new_vc_i[v*VCW +: VCW];
                    end
                end
                ST_ACTIVE: begin
                    // TAIL and HEADTAIL both have the upper label bit set.
                    if (sa_pop[v] && head[v][FLIT_W-1]) begin
                        state_d[v] = ST_IDLE;
                    end
                end
                default: state_d[v] = ST_IDLE;
            endcase
        end
    end

    // Flit storage is not reset; pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_NUM; v++) begin
            if (push[v]) begin
                mem_q[v][wr_ptr_q[v]] <= flit_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                rd_ptr_q[v]  <= '0;
                wr_ptr_q[v]  <= '0;
                count_q[v]   <= '0;
                state_q[v]   <= ST_IDLE;
                route_q[v]   <= PORT_LOCAL;
                down_vc_q[v] <= '0;
            end
            err_q          <= '0;
            credit_valid_q <= 1'b0;
            credit_vc_q    <= '0;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (push[v]) begin
                    wr_ptr_q[v] <= wr_ptr_q[v] + PW'(1);
                end
                if (pop[v]) begin
                    rd_ptr_q[v] <= rd_ptr_q[v] + PW'(1);
                end
                if (push[v] && !pop[v]) begin
                    count_q[v] <= count_q[v] + CW'(1);
                end else if (pop[v] && !push[v]) begin
                    count_q[v] <= count_q[v] - CW'(1);
                end
                state_q[v]   <= state_d[v];
                route_q[v]   <= route_d[v];
                down_vc_q[v] <= down_vc_d[v];
            end
            err_q          <= err_q | err_set;
            credit_valid_q <= |pop;
            credit_vc_q    <= pop_vc;
        end
    end

    always_comb begin
        for (int v = 0; v < VC_NUM; v++) begin
            va_request_o[v]      = (state_q[v] == ST_VA);
            sa_request_o[v]      = (state_q[v] == ST_ACTIVE) && !empty[v];
            out_port_o[v*3 +: 3] = route_q[v];
        end
    end

    assign is_empty_o     = empty;
    assign err_o          = err_q;
    assign credit_valid_o = credit_valid_q;
    assign credit_vc_o    = credit_vc_q;

endmodule

// File: tb/tb_input_port_credit.sv
// Directed bench for input_port_credit with default parameters (2 VCs, depth 8,
// 32-bit flits, router at X=Y=0).
module tb_input_port_credit;

    localparam logic [1:0] HEAD = 2'b00;
    localparam logic [1:0] BODY = 2'b01;
    localparam logic [1:0] TAIL = 2'b10;
    localparam logic [1:0] HT   = 2'b11;

    logic        clk;
    logic        rst = 1'b1;
    logic [31:0] flit_i;
    logic        valid_flit_i;
    logic [1:0]  va_valid_i;
    logic [1:0]  va_new_vc_i;
    logic        sa_valid_i;
    logic        sa_sel_vc_i;
    logic [31:0] xb_flit_o;
    logic        xb_valid_o;
    logic [1:0]  va_request_o;
    logic [1:0]  sa_request_o;
    logic [5:0]  out_port_o;
    logic        credit_valid_o;
    logic        credit_vc_o;
    logic [1:0]  is_empty_o;
    logic [1:0]  err_o;

    int n_chk  = 0;
    int n_fail = 0;

    input_port_credit dut (
        .clk            (clk),
        .rst            (rst),
        .flit_i         (flit_i),
        .valid_flit_i   (valid_flit_i),
        .va_valid_i     (va_valid_i),
        .va_new_vc_i    (va_new_vc_i),
        .sa_valid_i     (sa_valid_i),
        .sa_sel_vc_i    (sa_sel_vc_i),
        .xb_flit_o      (xb_flit_o),
        .xb_valid_o     (xb_valid_o),
        .va_request_o   (va_request_o),
        .sa_request_o   (sa_request_o),
        .out_port_o     (out_port_o),
        .credit_valid_o (credit_valid_o),
        .credit_vc_o    (credit_vc_o),
        .is_empty_o     (is_empty_o),
        .err_o          (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {label, vc_id, 17'b0, tag, y_dest, x_dest}
    function automatic logic [31:0] mk(input logic [1:0] lbl, input logic vc,
                                       input logic [7:0] tag, input logic [1:0] y,
                                       input logic [1:0] x);
        mk = {lbl, vc, 17'd0, tag, y, x};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flit_i       = '0;
        valid_flit_i = 1'b0;
        va_valid_i   = '0;
        va_new_vc_i  = '0;
        sa_valid_i   = 1'b0;
        sa_sel_vc_i  = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 rst = 1'b0;
        #2;
        n_chk++; if (is_empty_o !== 2'b11) begin n_fail++; $display("FAIL rst_empty: got %b exp 11", is_empty_o); end
        n_chk++; if (err_o !== 2'b00) begin n_fail++; $display("FAIL rst_err: got %b exp 00", err_o); end
        n_chk++; if (va_request_o !== 2'b00) begin n_fail++; $display("FAIL rst_va_req: got %b exp 00", va_request_o); end
        n_chk++; if (sa_request_o !== 2'b00) begin n_fail++; $display("FAIL rst_sa_req: got %b exp 00", sa_request_o); end
        n_chk++; if (out_port_o !== 6'd0) begin n_fail++; $display("FAIL rst_out_port: got %b exp 0", out_port_o); end
        n_chk++; if (credit_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_credit: got %b exp 0", credit_valid_o); end
        n_chk++; if (xb_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_xb_valid: got %b exp 0", xb_valid_o); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_route_credit();
        apply_reset();
        flit_i = mk(HEAD, 1'b1, 8'hA1, 2'd0, 2'd2); valid_flit_i = 1'b1;
        tick();
        valid_flit_i = 1'b0;
        n_chk++; if (is_empty_o !== 2'b01) begin n_fail++; $display("FAIL rc_wr_empty: got %b exp 01", is_empty_o); end
        n_chk++; if (va_request_o !== 2'b00) begin n_fail++; $display("FAIL rc_va_early: got %b exp 00", va_request_o); end
        tick();
        n_chk++; if (va_request_o !== 2'b10) begin n_fail++; $display("FAIL rc_va_req: got %b exp 10", va_request_o); end
        n_chk++; if (out_port_o !== 6'b100_000) begin n_fail++; $display("FAIL rc_route_e: got %b exp 100000", out_port_o); end
        va_valid_i = 2'b10; va_new_vc_i = 2'b00;
        tick();
        va_valid_i = 2'b00;
        n_chk++; if (va_request_o !== 2'b00) begin n_fail++; $display("FAIL rc_va_drop: got %b exp 00", va_request_o); end
        n_chk++; if (sa_request_o !== 2'b10) begin n_fail++; $display("FAIL rc_sa_req: got %b exp 10", sa_request_o); end
        sa_valid_i = 1'b1; sa_sel_vc_i = 1'b1;
        #1;
        n_chk++; if (xb_valid_o !== 1'b1) begin n_fail++; $display("FAIL rc_xb_valid: got %b exp 1", xb_valid_o); end
        n_chk++; if (xb_flit_o !== mk(HEAD, 1'b0, 8'hA1, 2'd0, 2'd2)) begin n_fail++; $display("FAIL rc_xb_flit: got %h exp %h", xb_flit_o, mk(HEAD, 1'b0, 8'hA1, 2'd0, 2'd2)); end
        tick();
        sa_valid_i = 1'b0;
        n_chk++; if (credit_valid_o !== 1'b1) begin n_fail++; $display("FAIL rc_credit: got %b exp 1", credit_valid_o); end
        n_chk++; if (credit_vc_o !== 1'b1) begin n_fail++; $display("FAIL rc_credit_vc: got %b exp 1", credit_vc_o); end
        n_chk++; if (is_empty_o !== 2'b11) begin n_fail++; $display("FAIL rc_drained: got %b exp 11", is_empty_o); end
        n_chk++; if (sa_request_o !== 2'b00) begin n_fail++; $display("FAIL rc_sa_empty: got %b exp 00", sa_request_o); end
        tick();
        n_chk++; if (credit_valid_o !== 1'b0) begin n_fail++; $display("FAIL rc_credit_once: got %b exp 0", credit_valid_o); end
        flit_i = mk(TAIL, 1'b1, 8'hA2, 2'd0, 2'd0); valid_flit_i = 1'b1;
        tick();
        valid_flit_i = 1'b0;
        n_chk++; if (sa_request_o !== 2'b10) begin n_fail++; $display("FAIL rc_sa_tail: got %b exp 10", sa_request_o); end
        sa_valid_i = 1'b1; sa_sel_vc_i = 1'b1;
        #1;
        n_chk++; if (xb_flit_o !== mk(TAIL, 1'b0, 8'hA2, 2'd0, 2'd0)) begin n_fail++; $display("FAIL rc_xb_tail: got %h exp %h", xb_flit_o, mk(TAIL, 1'b0, 8'hA2, 2'd0, 2'd0)); end
        tick();
        sa_valid_i = 1'b0;
        n_chk++; if (va_request_o !== 2'b00 || sa_request_o !== 2'b00) begin n_fail++; $display("FAIL rc_tail_idle: got va %b sa %b exp 00 00", va_request_o, sa_request_o); end
        n_chk++; if (err_o !== 2'b00) begin n_fail++; $display("FAIL rc_no_err: got %b exp 00", err_o); end
    endtask

    task automatic test_body_drop();
        apply_reset();
        flit_i = mk(BODY, 1'b0, 8'hB1, 2'd0, 2'd1); valid_flit_i = 1'b1;
        tick();
        valid_flit_i = 1'b0;
        n_chk++; if (err_o !== 2'b00) begin n_fail++; $display("FAIL bd_err_early: got %b exp 00", err_o); end
        n_chk++; if (is_empty_o !== 2'b10) begin n_fail++; $display("FAIL bd_stored: got %b exp 10", is_empty_o); end
        tick();
        n_chk++; if (err_o !== 2'b01) begin n_fail++; $display("FAIL bd_err: got %b exp 01", err_o); end
        n_chk++; if (credit_valid_o !== 1'b1 || credit_vc_o !== 1'b0) begin n_fail++; $display("FAIL bd_credit: got v%b vc%b exp v1 vc0", credit_valid_o, credit_vc_o); end
        n_chk++; if (is_empty_o !== 2'b11) begin n_fail++; $display("FAIL bd_popped: got %b exp 11", is_empty_o); end
        tick();
        n_chk++; if (va_request_o !== 2'b00) begin n_fail++; $display("FAIL bd_stay_idle: got %b exp 00", va_request_o); end
        n_chk++; if (credit_valid_o !== 1'b0) begin n_fail++; $display("FAIL bd_credit_once: got %b exp 0", credit_valid_o); end
    endtask

    task automatic test_overflow();
        logic [1:0] lbl;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            lbl = (i == 0) ? HEAD : ((i == 7) ? TAIL : BODY);
            flit_i = mk(lbl, 1'b0, 8'(8'h10 + i), 2'd0, 2'd1); valid_flit_i = 1'b1;
            tick();
        end
        valid_flit_i = 1'b0;
        n_chk++; if (err_o !== 2'b00) begin n_fail++; $display("FAIL of_err_early: got %b exp 00", err_o); end
        flit_i = mk(HEAD, 1'b0, 8'h18, 2'd0, 2'd1); valid_flit_i = 1'b1;
        tick();
        valid_flit_i = 1'b0;
        n_chk++; if (err_o !== 2'b01) begin n_fail++; $display("FAIL of_err: got %b exp 01", err_o); end
        n_chk++; if (is_empty_o !== 2'b10) begin n_fail++; $display("FAIL of_vc1_empty: got %b exp 10", is_empty_o); end
        n_chk++; if (va_request_o !== 2'b01) begin n_fail++; $display("FAIL of_va_req: got %b exp 01", va_request_o); end
        n_chk++; if (out_port_o !== 6'b000_100) begin n_fail++; $display("FAIL of_route: got %b exp 000100", out_port_o); end
        va_valid_i = 2'b01; va_new_vc_i = 2'b01;
        tick();
        va_valid_i = 2'b00;
        for (int i = 0; i < 8; i++) begin
            lbl = (i == 0) ? HEAD : ((i == 7) ? TAIL : BODY);
            sa_valid_i = 1'b1; sa_sel_vc_i = 1'b0;
            // Write while full and being read: must be accepted.
            if (i == 0) begin
                flit_i = mk(HT, 1'b0, 8'h20, 2'd2, 2'd0); valid_flit_i = 1'b1;
            end
            #1;
            n_chk++; if (xb_valid_o !== 1'b1 || xb_flit_o !== mk(lbl, 1'b1, 8'(8'h10 + i), 2'd0, 2'd1)) begin n_fail++; $display("FAIL of_drain[%0d]: got v%b %h exp v1 %h", i, xb_valid_o, xb_flit_o, mk(lbl, 1'b1, 8'(8'h10 + i), 2'd0, 2'd1)); end
            tick();
            valid_flit_i = 1'b0;
        end
        sa_valid_i = 1'b0;
        n_chk++; if (va_request_o !== 2'b00) begin n_fail++; $display("FAIL of_idle_gap: got %b exp 00", va_request_o); end
        n_chk++; if (is_empty_o !== 2'b10) begin n_fail++; $display("FAIL of_accepted: got %b exp 10", is_empty_o); end
        n_chk++; if (credit_valid_o !== 1'b1 || credit_vc_o !== 1'b0) begin n_fail++; $display("FAIL of_credit: got v%b vc%b exp v1 vc0", credit_valid_o, credit_vc_o); end
        tick();
        n_chk++; if (va_request_o !== 2'b01) begin n_fail++; $display("FAIL of_ht_va: got %b exp 01", va_request_o); end
        n_chk++; if (out_port_o !== 6'b000_010) begin n_fail++; $display("FAIL of_route_s: got %b exp 000010", out_port_o); end
        va_valid_i = 2'b01; va_new_vc_i = 2'b00;
        tick();
        va_valid_i = 2'b00;
        sa_valid_i = 1'b1; sa_sel_vc_i = 1'b0;
        #1;
        n_chk++; if (xb_flit_o !== mk(HT, 1'b0, 8'h20, 2'd2, 2'd0)) begin n_fail++; $display("FAIL of_ht_flit: got %h exp %h", xb_flit_o, mk(HT, 1'b0, 8'h20, 2'd2, 2'd0)); end
        tick();
        sa_valid_i = 1'b0;
        n_chk++; if (va_request_o !== 2'b00 || sa_request_o !== 2'b00 || is_empty_o !== 2'b11) begin n_fail++; $display("FAIL of_final: got va %b sa %b empty %b exp 00 00 11", va_request_o, sa_request_o, is_empty_o); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        flit_i = mk(HT, 1'b1, 8'h30, 2'd0, 2'd0); valid_flit_i = 1'b1;
        tick();
        flit_i = mk(HEAD, 1'b1, 8'h31, 2'd1, 2'd0);
        tick();
        valid_flit_i = 1'b0;
        n_chk++; if (va_request_o !== 2'b10) begin n_fail++; $display("FAIL bb_va_req: got %b exp 10", va_request_o); end
        n_chk++; if (out_port_o !== 6'b000_000) begin n_fail++; $display("FAIL bb_route_local: got %b exp 000000", out_port_o); end
        va_valid_i = 2'b10; va_new_vc_i = 2'b10;
        tick();
        va_valid_i = 2'b00;
        sa_valid_i = 1'b1; sa_sel_vc_i = 1'b1;
        #1;
        n_chk++; if (xb_flit_o !== mk(HT, 1'b1, 8'h30, 2'd0, 2'd0)) begin n_fail++; $display("FAIL bb_ht_flit: got %h exp %h", xb_flit_o, mk(HT, 1'b1, 8'h30, 2'd0, 2'd0)); end
        tick();
        sa_valid_i = 1'b0;
        n_chk++; if (va_request_o !== 2'b00 || sa_request_o !== 2'b00) begin n_fail++; $display("FAIL bb_gap: got va %b sa %b exp 00 00", va_request_o, sa_request_o); end
        n_chk++; if (is_empty_o !== 2'b01) begin n_fail++; $display("FAIL bb_queued: got %b exp 01", is_empty_o); end
        n_chk++; if (credit_valid_o !== 1'b1 || credit_vc_o !== 1'b1) begin n_fail++; $display("FAIL bb_credit: got v%b vc%b exp v1 vc1", credit_valid_o, credit_vc_o); end
        tick();
        n_chk++; if (va_request_o !== 2'b10) begin n_fail++; $display("FAIL bb_re_va: got %b exp 10", va_request_o); end
        n_chk++; if (out_port_o !== 6'b010_000) begin n_fail++; $display("FAIL bb_route_s: got %b exp 010000", out_port_o); end
    endtask

    task automatic test_bad_grant();
        apply_reset();
        sa_valid_i = 1'b1; sa_sel_vc_i = 1'b0;
        #1;
        n_chk++; if (xb_valid_o !== 1'b0 || xb_flit_o !== 32'd0) begin n_fail++; $display("FAIL bg_empty_xb: got v%b %h exp v0 0", xb_valid_o, xb_flit_o); end
        tick();
        sa_valid_i = 1'b0;
        n_chk++; if (err_o !== 2'b01) begin n_fail++; $display("FAIL bg_empty_err: got %b exp 01", err_o); end
        n_chk++; if (credit_valid_o !== 1'b0) begin n_fail++; $display("FAIL bg_no_credit: got %b exp 0", credit_valid_o); end
        flit_i = mk(HEAD, 1'b1, 8'h50, 2'd0, 2'd3); valid_flit_i = 1'b1;
        tick();
        valid_flit_i = 1'b0;
        tick();
        sa_valid_i = 1'b1; sa_sel_vc_i = 1'b1;
        #1;
        n_chk++; if (xb_valid_o !== 1'b0) begin n_fail++; $display("FAIL bg_va_xb: got %b exp 0", xb_valid_o); end
        tick();
        sa_valid_i = 1'b0;
        n_chk++; if (err_o !== 2'b11) begin n_fail++; $display("FAIL bg_va_err: got %b exp 11", err_o); end
        n_chk++; if (is_empty_o !== 2'b01) begin n_fail++; $display("FAIL bg_no_pop: got %b exp 01", is_empty_o); end
    endtask

    task automatic test_reset_mid_packet();
        apply_reset();
        flit_i = mk(HEAD, 1'b0, 8'h40, 2'd0, 2'd2); valid_flit_i = 1'b1;
        tick();
        flit_i = mk(BODY, 1'b0, 8'h41, 2'd0, 2'd0);
        tick();
        valid_flit_i = 1'b0;
        n_chk++; if (va_request_o !== 2'b01 || out_port_o !== 6'b000_100) begin n_fail++; $display("FAIL rm_pre: got va %b port %b exp 01 000100", va_request_o, out_port_o); end
        #2;
        rst = 1'b0;
        sa_valid_i = 1'b1; sa_sel_vc_i = 1'b0;
        #1;
        n_chk++; if (va_request_o !== 2'b00 || sa_request_o !== 2'b00) begin n_fail++; $display("FAIL rm_req: got va %b sa %b exp 00 00", va_request_o, sa_request_o); end
        n_chk++; if (is_empty_o !== 2'b11) begin n_fail++; $display("FAIL rm_empty: got %b exp 11", is_empty_o); end
        n_chk++; if (out_port_o !== 6'd0 || err_o !== 2'b00) begin n_fail++; $display("FAIL rm_regs: got port %b err %b exp 0 00", out_port_o, err_o); end
        n_chk++; if (xb_valid_o !== 1'b0 || credit_valid_o !== 1'b0) begin n_fail++; $display("FAIL rm_xb_credit: got xb %b cr %b exp 0 0", xb_valid_o, credit_valid_o); end
        sa_valid_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        n_chk++; if (va_request_o !== 2'b00 || is_empty_o !== 2'b11) begin n_fail++; $display("FAIL rm_after: got va %b empty %b exp 00 11", va_request_o, is_empty_o); end
    endtask

    initial begin
        test_reset();
        test_route_credit();
        test_body_drop();
        test_overflow();
        test_back_to_back();
        test_bad_grant();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
